serial_word_source: RTL
=======================

# serial_word_source

Parallel-to-serial stage that feeds the `1010` sequence-detector FSM. Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on `x_out`, with a qualifying `x_valid`. `x_out` connects directly to the detector's `x` input, on the same `clk` and `reset`. Supports back-to-back words with no idle gap, a synchronous flush, and a wrapping count of completed words.

## Interface
- `WIDTH`, 8: word length in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `x_out` when no bit is being sent.

- `clk`  in  1  clock, rising edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word to send.
- `load`  in  1  upstream valid; `din` is meaningful while high.
- `flush`  in  1  synchronous abort of the current word.
- `ready`  out  1  block can accept a word this cycle.
- `x_out`  out  1  serial bit; goes to the detector `x` input.
- `x_valid`  out  1  `x_out` carries a data bit this cycle.
- `last`  out  1  current `x_out` bit is the final bit of its word.
- `busy`  out  1  a word is in flight.
- `words_sent`  out  8  count of completed words, modulo 256.

## Operation
- States:
  - IDLE: no word in flight.
  - SHIFT: a word is being sent.
- Internal registers:
  - `shreg[WIDTH-1:0]`: word being shifted.
  - `bit_cnt`: index of the current bit, `$clog2(WIDTH)` bits wide, counting 0..WIDTH-1.
- Accept condition: `load && ready` sampled at a rising edge.
  - `din` is captured into `shreg` at that edge.
  - Later changes on `din` have no effect on the word in flight.
- `ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when `bit_cnt == WIDTH-1` and `flush` = 0.
  - 0 otherwise.
- IDLE, accept: go to SHIFT with `bit_cnt` = 0.
- SHIFT, `bit_cnt < WIDTH-1`: increment `bit_cnt` and shift `shreg` by one toward the output end.
- SHIFT, `bit_cnt == WIDTH-1`:
  - `words_sent` increments by 1, wrapping 255 → 0.
  - With an accept in the same cycle: reload `shreg` from `din`, set `bit_cnt` = 0, stay in SHIFT. There is no gap cycle.
  - Without an accept: go to IDLE.
- Output decode:
  - `x_out` = `shreg[WIDTH-1]` when MSB_FIRST = 1, else `shreg[0]`, in SHIFT.
  - `x_out` = IDLE_LEVEL in IDLE.
  - `x_valid` = `busy` = (state == SHIFT).
  - `last` = SHIFT && `bit_cnt == WIDTH-1`.
- `flush` = 1 at an edge, any state:
  - Next state is IDLE; `bit_cnt` is cleared.
  - A `load` in the same cycle is ignored, because `ready` is forced to 0.
  - `words_sent` is not incremented, even when the flushed bit was the last bit.
- `load` while `ready` = 0 is ignored. Upstream must hold `load` and `din` until it sees `ready`.

## Timing
- Reset (`reset` = 0, asynchronous): state IDLE, `shreg` = 0, `bit_cnt` = 0, `words_sent` = 0.
  - Resulting outputs: `x_out` = IDLE_LEVEL, `x_valid` = 0, `last` = 0, `busy` = 0, `ready` = 1.
  - Reset takes effect immediately, even mid-word; the partial word is discarded.
- Latency: word accepted at edge N.
  - Bit k is on `x_out` from edge N+k until edge N+k+1, for k = 0..WIDTH-1.
  - `last` is high in the cycle after edge N+WIDTH-1.
- `words_sent` shows the new count after edge N+WIDTH.
- Continuous back-to-back loading gives sustained throughput of 1 bit per clock.
- The detector samples `x_out` at the edge that ends each bit cycle, so each bit is seen exactly once.

## Test plan
- Basic word: reset, then WIDTH = 8, MSB_FIRST = 1, load `din` = 8'hA5 once. Required:
  - `x_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `x_valid` = 1.
  - `last` high on the 8th bit only.
  - `words_sent` = 1, then IDLE with `x_out` = 0.
  - The downstream detector's `y` rises after the 4th bit.
- Back-to-back: hold `load` high with 8'hF0 then 8'h0F. Required:
  - 16 contiguous valid bits 11110000 00001111.
  - `ready` pulses only on each `last` cycle.
  - `words_sent` = 2.
- LSB first: MSB_FIRST = 0, `din` = 8'h01. Required: `x_out` = 1,0,0,0,0,0,0,0.
- Flush: flush asserted during the 3rd bit of 8'hFF with `load` also high. Required:
  - IDLE on the next cycle, `x_valid` = 0.
  - `words_sent` unchanged.
  - The simultaneous `load` is not accepted.
- Reset mid-word: drive `reset` low during the 5th bit. Required:
  - All outputs immediately at their reset values.
  - After release, a new 8'hA5 is sent intact.
- Counter wrap: send 256 words back-to-back. Required:
  - `words_sent` reads 255 before the final completion and 0 after it.
  - No dropped bits.

Source files
------------

// File: rtl/serial_word_source.sv
// serial_word_source: parallel-to-serial stage feeding the 1010 sequence detector.
// Accepts a WIDTH-bit word on a load/ready handshake and emits it one bit per
// clock on x_out. Words can follow each other with no idle gap, a flush aborts
// the word in flight, and words_sent counts completed words modulo 256.
module serial_word_source #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             flush,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             last,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_nxt;
  logic [7:0]       words_nxt;
  logic             at_last;
  logic             accept;

  // The final bit of a word is on the wire; this is the only in-word cycle
  // where a new word may be taken, which keeps back-to-back words gapless.
  assign at_last = (state == SHIFT) && (bit_cnt == LAST_IDX);

  // Flush always wins: a load arriving together with it must be refused.
  assign ready  = !flush && ((state == IDLE) || at_last);
  assign accept = load && ready;

  assign x_valid = (state == SHIFT);
  assign busy    = (state == SHIFT);
  assign last    = at_last;

  // Outside a word the line rests at IDLE_LEVEL so the detector sees a stable value.
  assign x_out = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;

  // The register moves toward whichever end x_out is taken from.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // Next-state logic: flush, then accept/shift/complete decisions.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    words_nxt   = words_sent;
    if (flush) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_nxt   = SHIFT;
            shreg_nxt   = din;
            bit_cnt_nxt = '0;
          end
        end
        SHIFT: begin
          if (!at_last) begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = shreg_shifted;
          end else begin
            words_nxt = words_sent + 8'd1;
            if (accept) begin
              shreg_nxt   = din;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt   = IDLE;
              bit_cnt_nxt = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any partial word immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      words_sent <= 8'd0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      words_sent <= words_nxt;
    end
  end

endmodule
